minibyte_cpu_gen: RTL and testbench
===================================

// Module: minibyte_cpu_gen
// PURPOSE
//  Parametrised successor to the minibyte accumulator core: same A/M/PC/IR datapath
//  and single shared memory/IO bus, generalised in data/address width, plus a
//  memory ready handshake (wait states), one maskable interrupt with return, and halt.
//  Self-contained: register file, ALU and control FSM are internal; sits at chip top.
// PARAMETERS
//  DATA_W     8          data word width; must be >= ADDR_W and >= 8
//  ADDR_W     8          address width; operand address = operand word [ADDR_W-1:0]
//  RESET_VEC  0          PC value after reset
//  IRQ_VEC    all-ones   PC loaded on interrupt entry
// PORTS
//  clk_in       in   1       clock; all state changes on rising edge
//  rst_in       in   1       synchronous, active-high reset
//  data_in      in   DATA_W  read data from memory/IO
//  ready_in     in   1       access complete this cycle (sampled on clk_in edge)
//  irq_in       in   1       level interrupt request
//  addr_out     out  ADDR_W  bus address (PC in FETCH/OPER, M in EXEC)
//  data_out     out  DATA_W  always A register
//  we_out       out  1       write strobe (STA in EXEC only)
//  drive_out    out  1       drive data bus (equals we_out)
//  halt_out     out  1       high while in HALT
//  irq_ack_out  out  1       one-cycle pulse on interrupt entry
// BEHAVIOUR
//  Opcode = instruction word [DATA_W-1 -: 4]. 0 NOP, 1 LDI, 2 LDA, 3 STA, 4 ADD, 5 SUB,
//   6 AND, 7 OR, 8 XOR, 9 JMP, A JZ, B JN, C RTI, D HLT, E/F execute as NOP.
//  One-word ops: NOP RTI HLT E F. All others take one operand word, latched in M.
//  FSM: FETCH -> OPER (two-word ops) -> EXEC -> FETCH; one-word ops FETCH -> EXEC.
//   FETCH: addr=PC; on ready_in: IR<=data_in, PC<=PC+1 (wraps mod 2^ADDR_W).
//   OPER : addr=PC; on ready_in: M<=data_in, PC<=PC+1.
//   EXEC : LDI A<=M; JMP PC<=M; JZ/JN PC<=M if Z/N else no change; NOP 1 cycle.
//          LDA/ADD..XOR addr=M, wait ready_in, then A<=op(A,data_in).
//          STA addr=M, we_out=drive_out=1 held until ready_in; A unchanged.
//          RTI PC<=EPC, {Z,N}<=saved flags, IE<=1. HLT -> HALT.
//  Any state waiting on ready_in holds addr/we/drive stable; ready_in=0 stalls forever.
//  ADD/SUB modulo 2^DATA_W, no carry. Z=(result==0), N=result[DATA_W-1]; flags
//   update on LDI, LDA, ADD..XOR only.
//  Interrupt: checked only when entering FETCH (after EXEC) or in HALT. If irq_in&IE:
//   go to IRQ state (1 cycle): EPC<=PC, save {Z,N}, PC<=IRQ_VEC, IE<=0,
//   irq_ack_out=1; then FETCH. No nesting; irq_in ignored while IE=0.
//  HALT: halt_out=1, no bus access; leaves only via interrupt (IE=1) or reset.
//  Reset: PC=RESET_VEC, A=M=IR=EPC=0, Z=N=0, IE=1, state FETCH. Outputs next cycle:
//   addr_out=RESET_VEC, we_out=drive_out=halt_out=irq_ack_out=0.
//  Reset mid-access (e.g. STA with ready_in low): access abandoned, we_out low from
//   the first edge with rst_in high; no register update from that access.
//  Latency with ready_in=1: one-word ops 2 cycles, two-word ops 3, IRQ entry +1.
// TESTING
//  T1 reset, ready=1, mem: 0x10 0x05 0x40 0x20, [0x20]=0x03 -> A=0x05 then 0x08,
//     Z=0 N=0, PC=0x04 after 6 cycles.
//  T2 LDI 0x7F; SUB [x]=0x80 -> A=0xFF, N=1; JN 0x40 -> PC=0x40; JZ 0x50 not taken.
//  T3 STA 0x33 with ready_in low 3 cycles -> addr=0x33, we/drive high 4 cycles,
//     data_out=A, one write; next FETCH addr = PC.
//  T4 irq_in high during LDA -> LDA completes, IRQ cycle with irq_ack_out=1,
//     PC=IRQ_VEC; handler RTI -> PC/flags restored, second irq serviced after RTI only.
//  T5 HLT, IE=1 -> halt_out stays 1, no we; irq_in pulse -> wakes, PC=IRQ_VEC.
//  T6 DATA_W=16, ADDR_W=12: JMP 0xFFF then PC increments wrap to 0x000; ADD of
//     0xFFFF+0x0001 -> A=0x0000, Z=1; rst_in mid-STA -> we_out low next edge.

Source files
------------

// File: rtl/minibyte_cpu_gen.sv
// Minibyte accumulator CPU, parametrised: A/M/PC/IR datapath on one shared memory/IO bus
// with a ready handshake, one maskable interrupt with RTI return, and HLT.
module minibyte_cpu_gen #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] IRQ_VEC   = '1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready_in,
    input  logic              irq_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              we_out,
    output logic              drive_out,
    output logic              halt_out,
    output logic              irq_ack_out
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JN  = 4'hB;
    localparam logic [3:0] OP_RTI = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hD;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_OPER  = 3'd1,
        S_EXEC  = 3'd2,
        S_IRQ   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_epc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_m;
    logic [3:0]        r_ir;
    logic              r_z;
    logic              r_n;
    logic              r_ez;
    logic              r_en;
    logic              r_ie;

    logic [3:0]        w_op;
    logic [3:0]        w_fetch_op;
    logic [DATA_W-1:0] w_res;
    logic              w_exec_done;
    logic              w_irq_take;

    function automatic logic is_two_word(input logic [3:0] op);
        is_two_word = !(op == OP_NOP || op == OP_RTI || op == OP_HLT ||
                        op == 4'hE   || op == 4'hF);
    endfunction

    function automatic logic uses_bus(input logic [3:0] op);
        uses_bus = (op == OP_LDA || op == OP_STA || op == OP_ADD || op == OP_SUB ||
                    op == OP_AND || op == OP_OR  || op == OP_XOR);
    endfunction

    function automatic logic [DATA_W-1:0] alu_op(input logic [3:0]        op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  alu_op = a + b;
            OP_SUB:  alu_op = a - b;
            OP_AND:  alu_op = a & b;
            OP_OR:   alu_op = a | b;
            OP_XOR:  alu_op = a ^ b;
            default: alu_op = b;
        endcase
    endfunction

    // IR keeps only the opcode field; the low bits of the instruction word carry no meaning.
    assign w_op       = r_ir;
    assign w_fetch_op = data_in[DATA_W-1 -: 4];
    assign w_irq_take = irq_in & r_ie;
    assign w_res      = (w_op == OP_LDI) ? r_m : alu_op(w_op, r_a, data_in);

    assign data_out  = r_a;
    assign drive_out = we_out;

    always_comb begin
        w_state_nxt = r_state;
        addr_out    = r_pc;
        we_out      = 1'b0;
        halt_out    = 1'b0;
        irq_ack_out = 1'b0;
        w_exec_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (ready_in)
                    w_state_nxt = is_two_word(w_fetch_op) ? S_OPER : S_EXEC;
            end
            S_OPER: begin
                if (ready_in)
                    w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                addr_out    = r_m[ADDR_W-1:0];
                we_out      = (w_op == OP_STA);
                w_exec_done = uses_bus(w_op) ? ready_in : 1'b1;
                if (w_exec_done) begin
                    if (w_op == OP_HLT)
                        w_state_nxt = S_HALT;
                    else
                        w_state_nxt = w_irq_take ? S_IRQ : S_FETCH;
                end
            end
            S_IRQ: begin
                irq_ack_out = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                halt_out = 1'b1;
                if (w_irq_take)
                    w_state_nxt = S_IRQ;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Reset drops any access in flight: state returns to FETCH so we_out falls on that edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_VEC;
            r_epc   <= '0;
            r_a     <= '0;
            r_m     <= '0;
            r_ir    <= '0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_ez    <= 1'b0;
            r_en    <= 1'b0;
            r_ie    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_FETCH: begin
                    if (ready_in) begin
                        r_ir <= w_fetch_op;
                        r_pc <= r_pc + 1'b1;
                    end
                end
                S_OPER: begin
                    if (ready_in) begin
                        r_m  <= data_in;
                        r_pc <= r_pc + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_exec_done) begin
                        case (w_op)
                            OP_LDI, OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                r_a <= w_res;
                                r_z <= (w_res == '0);
                                r_n <= w_res[DATA_W-1];
                            end
                            OP_JMP: r_pc <= r_m[ADDR_W-1:0];
                            OP_JZ:  if (r_z) r_pc <= r_m[ADDR_W-1:0];
                            OP_JN:  if (r_n) r_pc <= r_m[ADDR_W-1:0];
                            OP_RTI: begin
                                r_pc <= r_epc;
                                r_z  <= r_ez;
                                r_n  <= r_en;
                                r_ie <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_IRQ: begin
                    r_epc <= r_pc;
                    r_ez  <= r_z;
                    r_en  <= r_n;
                    r_pc  <= IRQ_VEC;
                    r_ie  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minibyte_cpu_gen.sv
// Random-program bench for minibyte_cpu_gen: an instruction-level model predicts every bus
// write, interrupt count and final A; a 16/12-bit instance covers wrap and reset mid-STA.
module tb_minibyte_cpu_gen;

    localparam logic [7:0] IRQV1 = 8'hC0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1     = 1'b1;
    logic       rdy1     = 1'b1;
    logic       irq_line = 1'b0;
    logic [7:0] addr1, din1, dout1;
    logic       we1, drv1, halt1, ack1;
    logic [7:0] mem1 [256];
    assign din1 = mem1[addr1];

    minibyte_cpu_gen #(.DATA_W(8), .ADDR_W(8), .RESET_VEC(8'h00), .IRQ_VEC(IRQV1)) u_dut8 (
        .clk_in(clk), .rst_in(rst1), .data_in(din1), .ready_in(rdy1), .irq_in(irq_line),
        .addr_out(addr1), .data_out(dout1), .we_out(we1), .drive_out(drv1),
        .halt_out(halt1), .irq_ack_out(ack1));

    logic        rst2 = 1'b1;
    logic        rdy2 = 1'b1;
    logic [11:0] addr2;
    logic [15:0] din2, dout2;
    logic        we2, drv2, halt2, ack2;
    logic [15:0] mem2 [4096];
    assign din2 = mem2[addr2];

    minibyte_cpu_gen #(.DATA_W(16), .ADDR_W(12), .RESET_VEC(12'h100)) u_dut16 (
        .clk_in(clk), .rst_in(rst2), .data_in(din2), .ready_in(rdy2), .irq_in(1'b0),
        .addr_out(addr2), .data_out(dout2), .we_out(we2), .drive_out(drv2),
        .halt_out(halt2), .irq_ack_out(ack2));

    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] exp_wr1 [$];
    logic [27:0] exp_wr2 [$];
    logic        irq_pend = 1'b0;
    logic        irq_val  = 1'b0;
    logic        ext_set  = 1'b0;
    logic        ack_seen = 1'b0;
    int          ack_cnt  = 0;
    int          gp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_for(input string name, input int which, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if ((which == 0 && halt1) || (which == 1 && ack1) || (which == 2 && halt2))
                return;
        end
        n_checks++;
        n_err++;
        $display("FAIL %s: event not seen within %0d cycles", name, maxc);
    endtask

    // Device model: a write to 0xFE sets the irq line to bit 0; it takes effect after the edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst1) begin
            irq_line = 1'b0;
            irq_pend = 1'b0;
        end else begin
            if (irq_pend) begin
                irq_line = irq_val;
                irq_pend = 1'b0;
            end
            if (ext_set) begin
                irq_line = 1'b1;
                ext_set  = 1'b0;
            end
        end
        rdy1 = ($urandom_range(0, 3) != 0);
    end

    initial forever begin
        @(negedge clk);
        if (!rst1) begin
            if (we1)  check("drive_eq_we", drv1, 1);
            if (halt1) check("halt_no_we", we1, 0);
            if (we1 && rdy1) begin
                if (exp_wr1.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_write8: got addr %0h data %0h, required none", addr1, dout1);
                end else begin
                    check("write8", {addr1, dout1}, exp_wr1.pop_front());
                end
                mem1[addr1] = dout1;
                if (addr1 == 8'hFE) begin
                    irq_pend = 1'b1;
                    irq_val  = dout1[0];
                end
            end
            if (ack_seen) begin
                check("irq_entry_pc", addr1, IRQV1);
                ack_seen = 1'b0;
            end
            if (ack1) begin
                ack_cnt++;
                ack_seen = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst2) begin
            if (ack2) check("ack16_never", ack2, 0);
            if (we2 && rdy2) begin
                if (exp_wr2.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_write16: got addr %0h data %0h, required none", addr2, dout2);
                end else begin
                    check("write16", {addr2, dout2}, exp_wr2.pop_front());
                end
                mem2[addr2] = dout2;
            end
        end
    end

    task automatic put(input logic [7:0] b);
        mem1[gp[7:0]] = b;
        gp++;
    endtask

    task automatic gen_prog();
        int k;
        for (int i = 0; i < 256; i++) mem1[i] = 8'h00;
        for (int i = 'hD0; i <= 'hDF; i++) mem1[i] = 8'($urandom);
        // handler: save A, clear irq line, restore A, return
        gp = 'hC0;
        put(8'h30); put(8'hE0); put(8'h10); put(8'h00);
        put(8'h30); put(8'hFE); put(8'h20); put(8'hE0); put(8'hC0);
        gp = 0;
        while (gp < 'hB0) begin
            k = $urandom_range(0, 11);
            case (k)
                0:  begin put({4'h1, 4'($urandom)}); put(8'($urandom)); end
                1:  begin put({4'h2, 4'($urandom)}); put({4'hD, 4'($urandom)}); end
                2:  begin put({4'h3, 4'($urandom)}); put({4'hD, 4'($urandom)}); end
                8:  begin
                        put({($urandom_range(0, 1) != 0) ? 4'hA : 4'hB, 4'($urandom)});
                        put(8'(gp + 3));
                        put({4'h1, 4'($urandom)}); put(8'($urandom));
                    end
                9:  begin put(8'h10); put(8'h01); put(8'h30); put(8'hFE); end
                10: begin put({4'h9, 4'($urandom)}); put(8'(gp + 1)); end
                11: begin
                        k = $urandom_range(0, 2);
                        put({(k == 0) ? 4'h0 : ((k == 1) ? 4'hE : 4'hF), 4'($urandom)});
                    end
                default: begin put({4'(k + 1), 4'($urandom)}); put({4'hD, 4'($urandom)}); end
            endcase
        end
        put(8'h00); put({4'hD, 4'($urandom)}); put({4'hD, 4'($urandom)});
    endtask

    // Instruction-level reference: run from reset to the second HLT, waking once from HALT.
    task automatic run_model(output int nirq, output logic [7:0] fa);
        logic [7:0] m [256];
        logic [7:0] pc, a, epc, opd, ir;
        logic [3:0] op;
        logic       z, n, ez, en, ie, irq, irq_b, ie_b, halted, ext;
        for (int i = 0; i < 256; i++) m[i] = mem1[i];
        pc = 0; a = 0; epc = 0; opd = 0;
        z = 0; n = 0; ez = 0; en = 0; ie = 1; irq = 0; halted = 0; ext = 0; nirq = 0;
        for (int step = 0; step < 20000; step++) begin
            if (halted) begin
                if (irq && ie) begin
                    halted = 0;
                    epc = pc; ez = z; en = n; pc = IRQV1; ie = 0; nirq++;
                end else if (!ext) begin
                    irq = 1; ext = 1;
                end else begin
                    break;
                end
                continue;
            end
            ir = m[pc]; pc = pc + 1; op = ir[7:4];
            if (!(op inside {4'h0, 4'hC, 4'hD, 4'hE, 4'hF})) begin
                opd = m[pc]; pc = pc + 1;
            end
            irq_b = irq; ie_b = ie;
            case (op)
                4'h1: a = opd;
                4'h2: a = m[opd];
                4'h3: begin
                          m[opd] = a;
                          exp_wr1.push_back({opd, a});
                          if (opd == 8'hFE) irq = a[0];
                      end
                4'h4: a = a + m[opd];
                4'h5: a = a - m[opd];
                4'h6: a = a & m[opd];
                4'h7: a = a | m[opd];
                4'h8: a = a ^ m[opd];
                4'h9: pc = opd;
                4'hA: if (z) pc = opd;
                4'hB: if (n) pc = opd;
                4'hC: begin pc = epc; z = ez; n = en; ie = 1; end
                4'hD: halted = 1;
                default: ;
            endcase
            if (op inside {[4'h1:4'h2], [4'h4:4'h8]}) begin
                z = (a == 0); n = a[7];
            end
            if (!halted && irq_b && ie_b) begin
                epc = pc; ez = z; en = n; pc = IRQV1; ie = 0; nirq++;
            end
        end
        fa = a;
    endtask

    initial begin
        int          nirq;
        logic [7:0]  fa;
        int          found;
        for (int t = 0; t < 4; t++) begin
            rst1 = 1'b1;
            exp_wr1.delete();
            ack_cnt  = 0;
            ack_seen = 1'b0;
            gen_prog();
            run_model(nirq, fa);
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("rst_addr", addr1, 8'h00);
            check("rst_we", we1, 0);
            check("rst_drive", drv1, 0);
            check("rst_halt", halt1, 0);
            check("rst_ack", ack1, 0);
            check("rst_A", dout1, 8'h00);
            rst1 = 1'b0;
            wait_for("first_halt", 0, 5000);
            ext_set = 1'b1;
            wait_for("wake_ack", 1, 20);
            wait_for("second_halt", 0, 500);
            repeat (3) @(negedge clk);
            check("halt_held", halt1, 1);
            check("final_A", dout1, fa);
            check("irq_count", ack_cnt, nirq);
            check("writes_left8", exp_wr1.size(), 0);
        end

        for (int i = 0; i < 4096; i++) mem2[i] = 16'h0000;
        mem2['h100] = 16'h1000; mem2['h101] = 16'hFFFF;
        mem2['h102] = 16'h4000; mem2['h103] = 16'h0200;
        mem2['h104] = 16'h3000; mem2['h105] = 16'hF201;
        mem2['h106] = 16'h9000; mem2['h107] = 16'hFFFF;
        mem2['hFFF] = 16'h0000;
        mem2['h000] = 16'h3000; mem2['h001] = 16'h0202;
        mem2['h002] = 16'hA000; mem2['h003] = 16'h0010;
        mem2['h004] = 16'hD000;
        mem2['h010] = 16'h3000; mem2['h011] = 16'h0203;
        mem2['h012] = 16'hD000;
        mem2['h200] = 16'h0001;
        for (int i = 1; i <= 3; i++) exp_wr2.push_back({12'(12'h200 + i), 16'h0000});
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst16_addr", addr2, 12'h100);
        check("rst16_we", we2, 0);
        rst2 = 1'b0;
        wait_for("halt16", 2, 500);
        @(negedge clk);
        check("writes_left16", exp_wr2.size(), 0);
        check("add_wrap_A", dout2, 16'h0000);

        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (we2) begin
                found = 1;
                break;
            end
        end
        check("sta16_reached", found, 1);
        rdy2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("sta_hold_addr", addr2, 12'h201);
            check("sta_hold_we", we2, 1);
            check("sta_hold_drive", drv2, 1);
            check("sta_hold_data", dout2, 16'h0000);
        end
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        check("we_after_rst", we2, 0);
        check("drive_after_rst", drv2, 0);
        check("addr_after_rst", addr2, 12'h100);
        rdy2 = 1'b1;
        for (int i = 1; i <= 3; i++) exp_wr2.push_back({12'(12'h200 + i), 16'h0000});
        @(negedge clk);
        rst2 = 1'b0;
        wait_for("halt16_rerun", 2, 500);
        @(negedge clk);
        check("writes_left16_rerun", exp_wr2.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
